pipe_muldiv: RTL and testbench

Iterative multiply/divide unit owning the architectural Hi/Lo registers, sitting beside the execute-stage ALU. It replaces single-cycle Hi/Lo generation with a parametrised, multi-cycle engine for MULT/MULTU/DIV/DIVU and exposes a busy/done handshake for the hazard unit to stall on. It also supports direct Hi/Lo writes (MTHI/MTLO) and an abort for flushed instructions.

---
 rtl/pipe_muldiv_if.sv | 28 ++
 rtl/pipe_muldiv.sv | 210 +++++++++++++++++++++
 tb/tb_pipe_muldiv.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_muldiv_if.sv
// Handshake and Hi/Lo bus between the execute stage and the iterative multiply/divide unit.
// The master side drives requests and direct Hi/Lo writes; the slave side returns Hi/Lo and status.
interface pipe_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             abort;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b, abort, hi_we, lo_we, wdata,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, a, b, abort, hi_we, lo_we, wdata,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/pipe_muldiv.sv
// Iterative radix-2 multiply/divide engine owning the Hi/Lo registers.
// Operations run on magnitudes for WIDTH cycles, then signs are applied in a single fix-up cycle.
module pipe_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           clrn,
    pipe_muldiv_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;

    logic [1:0]       op_r;
    logic             sign_a_r;
    logic             sign_b_r;
    logic [WIDTH-1:0] a_orig_r;
    logic [WIDTH-1:0] opnd_r;      // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0] acc_r;       // product upper half or partial remainder
    logic [WIDTH-1:0] lo_side_r;   // multiplier being shifted out or quotient being shifted in
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             busy_r;
    logic             done_r;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    logic             accept_s;
    logic             in_signed_s;
    logic             a_neg_s;
    logic             b_neg_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;

    assign accept_s    = (state_r == ST_IDLE) && bus.start && !bus.abort;
    assign in_signed_s = ~bus.op[0];
    assign a_neg_s     = in_signed_s & bus.a[WIDTH-1];
    assign b_neg_s     = in_signed_s & bus.b[WIDTH-1];
    assign a_mag_s     = a_neg_s ? neg_w(bus.a) : bus.a;
    assign b_mag_s     = b_neg_s ? neg_w(bus.b) : bus.b;

    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   mul_sel_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH:0]   div_diff_s;

    // Multiply step: conditionally add, then shift {acc,mplr} right by one.
    assign mul_sum_s   = {1'b0, acc_r} + {1'b0, opnd_r};
    assign mul_sel_s   = lo_side_r[0] ? mul_sum_s : {1'b0, acc_r};
    // Divide step: bring in the next dividend bit and trial-subtract the divisor.
    assign div_shift_s = {acc_r, lo_side_r[WIDTH-1]};
    assign div_diff_s  = div_shift_s - {1'b0, opnd_r};

    logic             res_signed_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] res_hi_s;
    logic [WIDTH-1:0] res_lo_s;

    assign res_signed_s = ~op_r[0];
    assign prod_s       = {acc_r, lo_side_r};

    // Sign fix-up and special cases for the result written in FIX.
    always_comb begin
        res_hi_s = {WIDTH{1'b0}};
        res_lo_s = {WIDTH{1'b0}};
        if (op_r[1] == 1'b0) begin
            if (res_signed_s && (sign_a_r ^ sign_b_r)) begin
                {res_hi_s, res_lo_s} = neg_2w(prod_s);
            end else begin
                {res_hi_s, res_lo_s} = prod_s;
            end
        end else if (opnd_r == {WIDTH{1'b0}}) begin
            res_hi_s = a_orig_r;
            res_lo_s = {WIDTH{1'b1}};
        end else begin
            // Most-negative / -1 wraps naturally: magnitude 2^(W-1) negates to itself.
            res_lo_s = (res_signed_s && (sign_a_r ^ sign_b_r)) ? neg_w(lo_side_r) : lo_side_r;
            res_hi_s = (res_signed_s && sign_a_r) ? neg_w(acc_r) : acc_r;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_CALC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (bus.abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == CW'(WIDTH-1)) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_FIX:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and registered busy.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    // Operand capture and one radix-2 iteration per CALC cycle.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            op_r      <= 2'b00;
            sign_a_r  <= 1'b0;
            sign_b_r  <= 1'b0;
            a_orig_r  <= {WIDTH{1'b0}};
            opnd_r    <= {WIDTH{1'b0}};
            acc_r     <= {WIDTH{1'b0}};
            lo_side_r <= {WIDTH{1'b0}};
            cnt_r     <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r     <= bus.op;
                        sign_a_r <= a_neg_s;
                        sign_b_r <= b_neg_s;
                        a_orig_r <= bus.a;
                        acc_r    <= {WIDTH{1'b0}};
                        cnt_r    <= {CW{1'b0}};
                        if (bus.op[1]) begin
                            opnd_r    <= b_mag_s;
                            lo_side_r <= a_mag_s;
                        end else begin
                            opnd_r    <= a_mag_s;
                            lo_side_r <= b_mag_s;
                        end
                    end
                end
                ST_CALC: begin
                    cnt_r <= cnt_r + CW'(1);
                    if (op_r[1]) begin
                        if (!div_diff_s[WIDTH]) begin
                            acc_r     <= div_diff_s[WIDTH-1:0];
                            lo_side_r <= {lo_side_r[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_r     <= div_shift_s[WIDTH-1:0];
                            lo_side_r <= {lo_side_r[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_r     <= mul_sel_s[WIDTH:1];
                        lo_side_r <= {mul_sel_s[0], lo_side_r[WIDTH-1:1]};
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Architectural Hi/Lo: direct writes only while idle, results only from an unaborted FIX.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
            done_r <= 1'b0;
        end else begin
            done_r <= (state_r == ST_FIX) && !bus.abort;
            if (state_r == ST_IDLE) begin
                if (bus.hi_we) begin
                    hi_r <= bus.wdata;
                end
                if (bus.lo_we) begin
                    lo_r <= bus.wdata;
                end
            end else if ((state_r == ST_FIX) && !bus.abort) begin
                hi_r <= res_hi_s;
                lo_r <= res_lo_s;
            end
        end
    end

    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
endmodule

// File: tb/tb_pipe_muldiv.sv
// Self-checking bench for pipe_muldiv: fixed vector table, randomized ops against an arithmetic
// model, plus hand-written reset/abort/back-to-back/WIDTH=8 sequences.
module tb_pipe_muldiv;
    logic clk = 1'b0;
    logic clrn;
    always #5 clk = ~clk;

    pipe_muldiv_if #(.WIDTH(32)) bus32();
    pipe_muldiv_if #(.WIDTH(8))  bus8();

    pipe_muldiv #(.WIDTH(32)) dut32 (.clk(clk), .clrn(clrn), .bus(bus32));
    pipe_muldiv #(.WIDTH(8))  dut8  (.clk(clk), .clrn(clrn), .bus(bus8));

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint      sa, sb, q, r;
        logic [63:0] v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h = 32'd0;
        l = 32'd0;
        case (op)
            2'b00: begin v = sa * sb; h = v[63:32]; l = v[31:0]; end
            2'b01: begin v = {32'd0, a} * {32'd0, b}; h = v[63:32]; l = v[31:0]; end
            2'b10: begin
                if (b == 32'd0) begin h = a; l = 32'hFFFF_FFFF; end
                else begin q = sa / sb; r = sa % sb; v = q; l = v[31:0]; v = r; h = v[31:0]; end
            end
            default: begin
                if (b == 32'd0) begin h = a; l = 32'hFFFF_FFFF; end
                else begin l = a / b; h = a % b; end
            end
        endcase
    endfunction

    task automatic start32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus32.op = op; bus32.a = a; bus32.b = b; bus32.start = 1'b1;
        tick();
        bus32.start = 1'b0;
    endtask

    task automatic wait32(output int lat);
        lat = 1;
        while (bus32.done !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic check32(input string name, input int lat, input logic [31:0] eh, input logic [31:0] el);
        chk({name, ".latency"}, 64'(lat), 64'd34);
        chk({name, ".hi"}, {32'd0, bus32.hi}, {32'd0, eh});
        chk({name, ".lo"}, {32'd0, bus32.lo}, {32'd0, el});
        chk({name, ".busy"}, {63'd0, bus32.busy}, 64'd0);
    endtask

    task automatic run32(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el);
        int lat;
        start32(op, a, b);
        wait32(lat);
        check32(name, lat, eh, el);
        tick();
        chk({name, ".done_pulse"}, {63'd0, bus32.done}, 64'd0);
    endtask

    task automatic run8(input string name, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eh, input logic [7:0] el);
        int lat;
        bus8.op = op; bus8.a = a; bus8.b = b; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        lat = 1;
        while (bus8.done !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        chk({name, ".latency"}, 64'(lat), 64'd10);
        chk({name, ".hi"}, {56'd0, bus8.hi}, {56'd0, eh});
        chk({name, ".lo"}, {56'd0, bus8.lo}, {56'd0, el});
        tick();
    endtask

    initial begin
        logic [31:0] eh, el, ra, rb;
        logic [1:0]  rop;
        int          lat, dones;

        vecs[0] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4] = '{2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};
        vecs[5] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[6] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[8] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};

        bus32.start = 1'b0; bus32.op = 2'b00; bus32.a = 32'd0; bus32.b = 32'd0;
        bus32.abort = 1'b0; bus32.hi_we = 1'b0; bus32.lo_we = 1'b0; bus32.wdata = 32'd0;
        bus8.start = 1'b0; bus8.op = 2'b00; bus8.a = 8'd0; bus8.b = 8'd0;
        bus8.abort = 1'b0; bus8.hi_we = 1'b0; bus8.lo_we = 1'b0; bus8.wdata = 8'd0;
        clrn = 1'b0;
        repeat (3) tick();
        chk("reset.hi", {32'd0, bus32.hi}, 64'd0);
        chk("reset.lo", {32'd0, bus32.lo}, 64'd0);
        chk("reset.busy", {63'd0, bus32.busy}, 64'd0);
        chk("reset.done", {63'd0, bus32.done}, 64'd0);
        clrn = 1'b1;
        tick();

        // Direct Hi/Lo writes
        bus32.hi_we = 1'b1; bus32.wdata = 32'hDEAD_BEEF; tick(); bus32.hi_we = 1'b0;
        chk("mthi", {32'd0, bus32.hi}, 64'hDEAD_BEEF);
        bus32.lo_we = 1'b1; bus32.wdata = 32'h1234_5678; tick(); bus32.lo_we = 1'b0;
        chk("mtlo", {32'd0, bus32.lo}, 64'h1234_5678);

        // Asynchronous reset in the middle of a MULTU
        start32(2'b01, 32'hFFFF_FFFF, 32'h0000_0003);
        repeat (5) tick();
        #2 clrn = 1'b0;
        #1;
        chk("rst_mid.hi", {32'd0, bus32.hi}, 64'd0);
        chk("rst_mid.lo", {32'd0, bus32.lo}, 64'd0);
        chk("rst_mid.busy", {63'd0, bus32.busy}, 64'd0);
        chk("rst_mid.done", {63'd0, bus32.done}, 64'd0);
        tick();
        clrn = 1'b1;
        tick();
        run32("after_rst", 2'b01, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFD);

        for (int i = 0; i < 10; i++) begin
            run32($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
        end

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(16, 31);
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            ref32(rop, ra, rb, eh, el);
            run32($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, eh, el);
        end

        // Back-to-back: second start issued in the done cycle
        start32(2'b00, 32'd3, 32'hFFFF_FFFC);
        wait32(lat);
        check32("b2b_first", lat, 32'hFFFF_FFFF, 32'hFFFF_FFF4);
        start32(2'b11, 32'd100, 32'd7);
        wait32(lat);
        check32("b2b_second", lat, 32'd2, 32'd14);
        tick();

        // Direct writes together with an accepted start
        bus32.hi_we = 1'b1; bus32.lo_we = 1'b1; bus32.wdata = 32'hCAFE_0000;
        bus32.op = 2'b01; bus32.a = 32'd3; bus32.b = 32'd4; bus32.start = 1'b1;
        tick();
        bus32.hi_we = 1'b0; bus32.lo_we = 1'b0; bus32.start = 1'b0;
        chk("we_start.hi", {32'd0, bus32.hi}, 64'hCAFE_0000);
        chk("we_start.busy", {63'd0, bus32.busy}, 64'd1);
        wait32(lat);
        check32("we_start_result", lat, 32'd0, 32'd12);
        tick();

        // Abort mid-CALC; start and hi_we during busy are ignored
        bus32.hi_we = 1'b1; bus32.wdata = 32'h0000_AAAA; tick(); bus32.hi_we = 1'b0;
        bus32.lo_we = 1'b1; bus32.wdata = 32'h0000_5555; tick(); bus32.lo_we = 1'b0;
        start32(2'b01, 32'd5, 32'd6);
        repeat (4) tick();
        bus32.start = 1'b1; bus32.hi_we = 1'b1; bus32.wdata = 32'h0000_1234;
        tick();
        bus32.start = 1'b0; bus32.hi_we = 1'b0;
        chk("busy_we.hi", {32'd0, bus32.hi}, 64'h0000_AAAA);
        chk("busy_we.busy", {63'd0, bus32.busy}, 64'd1);
        repeat (4) tick();
        bus32.abort = 1'b1;
        tick();
        bus32.abort = 1'b0;
        chk("abort.busy", {63'd0, bus32.busy}, 64'd0);
        chk("abort.done", {63'd0, bus32.done}, 64'd0);
        chk("abort.hi", {32'd0, bus32.hi}, 64'h0000_AAAA);
        chk("abort.lo", {32'd0, bus32.lo}, 64'h0000_5555);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus32.done === 1'b1) dones++;
        end
        chk("abort.no_done", 64'(dones), 64'd0);
        chk("abort.hi_after", {32'd0, bus32.hi}, 64'h0000_AAAA);

        // Abort together with start in IDLE: start is dropped
        bus32.start = 1'b1; bus32.abort = 1'b1; bus32.op = 2'b01;
        tick();
        bus32.start = 1'b0; bus32.abort = 1'b0;
        chk("abort_start.busy", {63'd0, bus32.busy}, 64'd0);

        // Narrow instance
        run8("w8_mult", 2'b00, 8'hFF, 8'h02, 8'hFF, 8'hFE);
        run8("w8_div_wrap", 2'b10, 8'h80, 8'hFF, 8'h00, 8'h80);
        run8("w8_divu", 2'b11, 8'd200, 8'd9, 8'd2, 8'd22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
